// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NREQ requesters.
// It captures the winner's word, runs the sd_en start handshake, and waits for the frame to finish.
module uart_tx_arbiter #(
   parameter int          NREQ    = 2,
   parameter int          SD_LEN  = 2,
   parameter logic [15:0] BUSY_TO = 16'd64,
   parameter logic [15:0] GAP     = 16'd0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [16*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   ack,
   output logic [NREQ-1:0]   done,
   input  logic              err_clr,
   output logic [15:0]       tx_data,
   output logic              tx_sd_en,
   input  logic              tx_flag,
   input  logic              tx_ft,
   output logic              busy,
   output logic [1:0]        grant_id,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PULSE,
      WAIT_BUSY,
      WAIT_DONE,
      GAP_W,
      ERR
   } state_e;

   state_e          state_q, state_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [1:0]      rr_q, rr_d;
   logic [1:0]      grant_q, grant_d;
   logic [15:0]     data_q, data_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [NREQ-1:0] done_q, done_d;

   logic            anyReq;
   int              candIdx;
   int              pickIdx;
   logic [15:0]     pickData;
   logic            grantNow;
   logic            doneNow;

   // Cyclic search upward from the last winner; iterating from the far end
   // down lets the nearest pending requester overwrite the earlier candidates.
   always_comb begin
      anyReq   = 1'b0;
      candIdx  = 0;
      pickIdx  = 0;
      pickData = '0;
      for (int k = NREQ; k >= 1; k--) begin
         candIdx = (int'(rr_q) + k) % NREQ;
         if (req[candIdx]) begin
            anyReq   = 1'b1;
            pickIdx  = candIdx;
            pickData = req_data[16*candIdx +: 16];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rr_d     = rr_q;
      grant_d  = grant_q;
      data_d   = data_q;
      grantNow = 1'b0;
      doneNow  = 1'b0;

      case (state_q)
         IDLE: begin
            if (!tx_ft) begin
               state_d = ERR;
            end else if (anyReq) begin
               grantNow = 1'b1;
               grant_d  = 2'(pickIdx);
               rr_d     = 2'(pickIdx);
               data_d   = pickData;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = PULSE;
         end
         PULSE: begin
            if (cnt_q == 16'(SD_LEN - 1)) begin
               cnt_d   = '0;
               state_d = WAIT_BUSY;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         WAIT_BUSY: begin
            if (tx_flag) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == BUSY_TO - 16'd1) begin
               state_d = ERR;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         WAIT_DONE: begin
            if (!tx_flag) begin
               doneNow = 1'b1;
               cnt_d   = '0;
               state_d = (GAP != 16'd0) ? GAP_W : IDLE;
            end
         end
         GAP_W: begin
            if (cnt_q == GAP - 16'd1) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ERR: begin
            if (err_clr) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A transmitter fault outranks every in-flight step, including a finishing frame.
      if (!tx_ft && (state_q != IDLE) && (state_q != ERR)) begin
         state_d = ERR;
         doneNow = 1'b0;
      end
   end

   always_comb begin
      ack_d  = '0;
      done_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         ack_d[i]  = grantNow && (pickIdx == i);
         done_d[i] = doneNow && (int'(grant_q) == i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rr_q    <= 2'(NREQ - 1);
         grant_q <= '0;
         data_q  <= '0;
         ack_q   <= '0;
         done_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
      end
   end

   assign ack      = ack_q;
   assign done     = done_q;
   assign tx_data  = data_q;
   assign grant_id = grant_q;
   assign tx_sd_en = (state_q == PULSE);
   assign busy     = (state_q != IDLE) && (state_q != ERR);
   assign err      = (state_q == ERR);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table vectors, directed corner sequences,
// and a randomized run scored against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

   localparam int NREQ = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [15:0] word0, word1;
   logic [31:0] reqData;
   logic [1:0]  ack, done;
   logic        errClr;
   logic [15:0] txData;
   logic        txSdEn, txFlag, txFt, busy, err;
   logic [1:0]  grantId;

   logic [1:0]  gReq;
   logic [15:0] gWord0, gWord1;
   logic [31:0] gReqData;
   logic [1:0]  gAck, gDone;
   logic [15:0] gTxData;
   logic        gSdEn, gBusy, gErr;
   logic [1:0]  gGrant;

   assign reqData  = {word1, word0};
   assign gReqData = {gWord1, gWord0};

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NREQ(NREQ)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(reqData), .ack(ack), .done(done),
      .err_clr(errClr), .tx_data(txData), .tx_sd_en(txSdEn), .tx_flag(txFlag),
      .tx_ft(txFt), .busy(busy), .grant_id(grantId), .err(err)
   );

   uart_tx_arbiter #(.NREQ(NREQ), .GAP(16'd10)) dutGap (
      .clk(clk), .rst(rst), .req(gReq), .req_data(gReqData), .ack(gAck), .done(gDone),
      .err_clr(1'b0), .tx_data(gTxData), .tx_sd_en(gSdEn), .tx_flag(txFlag),
      .tx_ft(1'b1), .busy(gBusy), .grant_id(gGrant), .err(gErr)
   );

   // Transmitter stand-in: flag rises flagDelay cycles after an sd_en rising edge
   // and stays up for about frameLen cycles; noFlag models a dead transmitter.
   int   flagDelay, frameLen;
   int   txCnt = 0;
   logic noFlag, useGap, sdPrev, mSd;
   assign mSd    = useGap ? gSdEn : txSdEn;
   assign txFlag = (txCnt != 0) && (txCnt >= flagDelay);

   always @(posedge clk) begin
      if (rst) begin
         sdPrev <= 1'b0;
         txCnt  <= 0;
      end else begin
         sdPrev <= mSd;
         if (mSd && !sdPrev && !noFlag) txCnt <= 1;
         else if (txCnt != 0 && txCnt < flagDelay + frameLen) txCnt <= txCnt + 1;
         else txCnt <= 0;
      end
   end

   int passCount = 0;
   int totalCount = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      totalCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic [1:0] r, input logic [15:0] d0, input logic [15:0] d1);
      req   = r;
      word0 = d0;
      word1 = d1;
   endtask

   task automatic stepClock;
      @(posedge clk);
      #1;
   endtask

   function automatic int rrPick(input logic [1:0] pend, input int last);
      for (int k = 1; k <= NREQ; k++)
         if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [1:0] oneHot(input int i);
      return 2'(1 << i);
   endfunction

   typedef struct {
      logic [1:0]  reqs;
      logic [15:0] d0, d1;
      int          fDelay, fLen;
      logic [1:0]  expAck;
      logic [1:0]  expGid;
      logic [15:0] expData;
   } vec_t;

   vec_t vecs[7];

   int          sdHigh, cnt, gapCnt, frameAge, pick, modelLast;
   logic        holdBad, doneSeen, frameOpen, wasOpen, expectAck;
   logic [1:0]  prevReq;
   logic [15:0] expData;
   int          ctIdx[3];
   logic [15:0] ctData[3];

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vecs[0] = '{2'b01, 16'h00A5, 16'h1111, 3, 100, 2'b01, 2'd0, 16'h00A5};
      vecs[1] = '{2'b11, 16'h0011, 16'h0022, 2, 10,  2'b10, 2'd1, 16'h0022};
      vecs[2] = '{2'b11, 16'h0033, 16'h0044, 1, 6,   2'b01, 2'd0, 16'h0033};
      vecs[3] = '{2'b10, 16'h0000, 16'hBEEF, 4, 8,   2'b10, 2'd1, 16'hBEEF};
      vecs[4] = '{2'b10, 16'h0000, 16'hCAFE, 2, 5,   2'b10, 2'd1, 16'hCAFE};
      vecs[5] = '{2'b01, 16'h1234, 16'h0000, 5, 12,  2'b01, 2'd0, 16'h1234};
      vecs[6] = '{2'b11, 16'h5555, 16'hAAAA, 3, 7,   2'b10, 2'd1, 16'hAAAA};
      ctIdx   = '{0, 1, 0};
      ctData  = '{16'h0011, 16'h0022, 16'h0011};

      rst = 1'b1; errClr = 1'b0; txFt = 1'b1; noFlag = 1'b0; useGap = 1'b0;
      flagDelay = 3; frameLen = 100;
      gReq = 2'b00; gWord0 = '0; gWord1 = '0;
      applyStimulus(2'b00, 16'h0000, 16'h0000);
      repeat (3) stepClock;
      checkOutput("rst_ack", ack, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_sd_en", txSdEn, 0);
      checkOutput("rst_grant", grantId, 0);
      checkOutput("rst_tx_data", txData, 0);
      rst = 1'b0;
      stepClock;

      for (int v = 0; v < 7; v++) begin
         flagDelay = vecs[v].fDelay;
         frameLen  = vecs[v].fLen;
         applyStimulus(vecs[v].reqs, vecs[v].d0, vecs[v].d1);
         stepClock;
         checkOutput($sformatf("vec%0d_ack", v), ack, vecs[v].expAck);
         checkOutput($sformatf("vec%0d_grant", v), grantId, vecs[v].expGid);
         checkOutput($sformatf("vec%0d_data", v), txData, vecs[v].expData);
         req = 2'b00;
         sdHigh = 0;
         holdBad = 1'b0;
         for (int n = 0; n < 400 && done == 2'b00; n++) begin
            stepClock;
            if (txSdEn) sdHigh++;
            if (busy && txData !== vecs[v].expData) holdBad = 1'b1;
         end
         checkOutput($sformatf("vec%0d_done", v), done, vecs[v].expAck);
         checkOutput($sformatf("vec%0d_sd_len", v), sdHigh, 2);
         checkOutput($sformatf("vec%0d_hold", v), holdBad, 0);
         checkOutput($sformatf("vec%0d_idle", v), busy, 0);
         stepClock;
         checkOutput($sformatf("vec%0d_done_pulse", v), done, 0);
      end

      // Reset in the middle of PULSE, then continuous contention from a fresh pointer.
      flagDelay = 3; frameLen = 20;
      applyStimulus(2'b01, 16'h0F0F, 16'h0000);
      stepClock;
      req = 2'b00;
      for (int n = 0; n < 10 && !txSdEn; n++) stepClock;
      checkOutput("mr_pulse_seen", txSdEn, 1);
      rst = 1'b1;
      applyStimulus(2'b11, 16'h0011, 16'h0022);
      stepClock;
      checkOutput("mr_sd_en", txSdEn, 0);
      checkOutput("mr_ack", ack, 0);
      checkOutput("mr_done", done, 0);
      checkOutput("mr_err", err, 0);
      checkOutput("mr_grant", grantId, 0);
      checkOutput("mr_busy", busy, 0);
      rst = 1'b0;
      for (int f = 0; f < 3; f++) begin
         for (int n = 0; n < 400 && ack == 2'b00; n++) stepClock;
         checkOutput($sformatf("ct%0d_ack", f), ack, oneHot(ctIdx[f]));
         checkOutput($sformatf("ct%0d_grant", f), grantId, 2'(ctIdx[f]));
         checkOutput($sformatf("ct%0d_data", f), txData, ctData[f]);
         if (f == 2) req = 2'b00;
         stepClock;
         checkOutput($sformatf("ct%0d_ack_pulse", f), ack, 0);
      end
      for (int n = 0; n < 400 && done == 2'b00; n++) stepClock;
      checkOutput("ct_last_done", done, 2'b01);

      // Transmitter never raises its flag.
      noFlag = 1'b1;
      applyStimulus(2'b01, 16'h7777, 16'h0000);
      for (int n = 0; n < 20 && ack == 2'b00; n++) stepClock;
      checkOutput("to_ack", ack, 2'b01);
      req = 2'b00;
      for (int n = 0; n < 20 && !txSdEn; n++) stepClock;
      for (int n = 0; n < 20 && txSdEn; n++) stepClock;
      cnt = 0;
      doneSeen = 1'b0;
      while (!err && cnt < 200) begin
         stepClock;
         cnt++;
         if (done != 2'b00) doneSeen = 1'b1;
      end
      checkOutput("to_cycles", cnt, 64);
      checkOutput("to_busy", busy, 0);
      checkOutput("to_sd_en", txSdEn, 0);
      checkOutput("to_no_done", doneSeen, 0);
      applyStimulus(2'b01, 16'h8888, 16'h0000);
      repeat (3) stepClock;
      checkOutput("to_no_ack_in_err", ack, 0);
      checkOutput("to_err_sticky", err, 1);
      noFlag = 1'b0; flagDelay = 2; frameLen = 10;
      errClr = 1'b1;
      stepClock;
      errClr = 1'b0;
      checkOutput("to_clr_err", err, 0);
      checkOutput("to_clr_ack", ack, 0);
      stepClock;
      checkOutput("to_reack", ack, 2'b01);
      checkOutput("to_reack_data", txData, 16'h8888);
      req = 2'b00;
      for (int n = 0; n < 200 && done == 2'b00; n++) stepClock;
      checkOutput("to_final_done", done, 2'b01);

      // Transmitter fault while waiting for frame completion.
      flagDelay = 3; frameLen = 40;
      applyStimulus(2'b01, 16'h1234, 16'h0000);
      stepClock;
      checkOutput("ft_ack", ack, 2'b01);
      req = 2'b00;
      for (int n = 0; n < 30 && !txFlag; n++) stepClock;
      stepClock;
      txFt = 1'b0;
      stepClock;
      checkOutput("ft_err", err, 1);
      checkOutput("ft_sd_en", txSdEn, 0);
      checkOutput("ft_busy", busy, 0);
      doneSeen = 1'b0;
      repeat (5) begin
         stepClock;
         if (done != 2'b00) doneSeen = 1'b1;
      end
      checkOutput("ft_sticky", err, 1);
      checkOutput("ft_no_done", doneSeen, 0);
      errClr = 1'b1;
      stepClock;
      errClr = 1'b0;
      checkOutput("ft_clr_priority", err, 0);
      stepClock;
      checkOutput("ft_refault", err, 1);
      txFt = 1'b1;
      errClr = 1'b1;
      stepClock;
      errClr = 1'b0;
      checkOutput("ft_clr_ok", err, 0);
      stepClock;
      checkOutput("ft_stays_clear", err, 0);
      checkOutput("ft_idle", busy, 0);
      for (int n = 0; n < 100 && txCnt != 0; n++) stepClock;

      // Idle gap between a done pulse and the next grant.
      useGap = 1'b1; flagDelay = 2; frameLen = 5;
      gWord0 = 16'h0101; gWord1 = 16'h0202; gReq = 2'b11;
      for (int n = 0; n < 20 && gAck == 2'b00; n++) stepClock;
      checkOutput("gap_first_ack", gAck, 2'b01);
      checkOutput("gap_first_data", gTxData, 16'h0101);
      for (int f = 1; f <= 2; f++) begin
         for (int n = 0; n < 200 && gDone == 2'b00; n++) stepClock;
         checkOutput($sformatf("gap%0d_done", f), gDone, oneHot((f + 1) % 2));
         gapCnt = 0;
         stepClock;
         while (gAck == 2'b00 && gapCnt < 40) begin
            gapCnt++;
            stepClock;
         end
         checkOutput($sformatf("gap%0d_idle_cycles", f), gapCnt, 10);
         checkOutput($sformatf("gap%0d_ack", f), gAck, oneHot(f % 2));
         checkOutput($sformatf("gap%0d_grant", f), gGrant, 2'(f % 2));
         checkOutput($sformatf("gap%0d_data", f), gTxData, (f % 2) ? 16'h0202 : 16'h0101);
      end
      gReq = 2'b00;
      for (int n = 0; n < 200 && gDone == 2'b00; n++) stepClock;
      checkOutput("gap_final_done", gDone, 2'b01);
      stepClock;
      checkOutput("gap_busy_in_gap", gBusy, 1);
      checkOutput("gap_no_err", gErr, 0);
      for (int n = 0; n < 40 && gBusy; n++) stepClock;
      useGap = 1'b0;

      // Randomized traffic against the round-robin transaction model.
      rst = 1'b1;
      applyStimulus(2'b00, 16'h0000, 16'h0000);
      repeat (2) stepClock;
      rst = 1'b0;
      modelLast = NREQ - 1;
      frameOpen = 1'b0;
      frameAge  = 0;
      sdHigh    = 0;
      expData   = '0;
      for (int c = 0; c < 2500 || (c < 6000 && (req != 2'b00 || frameOpen)); c++) begin
         prevReq = req;
         stepClock;
         wasOpen   = frameOpen;
         expectAck = !frameOpen && (prevReq != 2'b00);
         pick      = expectAck ? rrPick(prevReq, modelLast) : -1;
         checkOutput("rand_ack", ack, expectAck ? oneHot(pick) : 2'b00);
         if (expectAck) begin
            expData = (pick == 1) ? word1 : word0;
            checkOutput("rand_data", txData, expData);
            modelLast = pick;
            frameOpen = 1'b1;
            frameAge  = 0;
            sdHigh    = 0;
            req[pick] = 1'b0;
            flagDelay = $urandom_range(1, 5);
            frameLen  = $urandom_range(2, 20);
         end else if (wasOpen) begin
            frameAge++;
            if (txSdEn) sdHigh++;
            if (busy) checkOutput("rand_hold", txData, expData);
            if (done != 2'b00) begin
               checkOutput("rand_done", done, oneHot(modelLast));
               checkOutput("rand_sd_len", sdHigh, 2);
               frameOpen = 1'b0;
            end else if (frameAge > 300) begin
               checkOutput("rand_frame_bound", frameAge, 300);
               frameOpen = 1'b0;
            end
         end
         if (!wasOpen) checkOutput("rand_no_stray_done", done, 0);
         if (c < 2500) begin
            for (int i = 0; i < NREQ; i++) begin
               if (!req[i] && $urandom_range(0, 3) == 0) begin
                  if (i == 0) word0 = 16'($urandom);
                  else        word1 = 16'($urandom);
                  req[i] = 1'b1;
               end
            end
         end
      end
      checkOutput("rand_drained", {frameOpen, req}, 0);
      checkOutput("rand_no_err", err, 0);

      $display("[TB] %0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
